// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   - seqState_e : sort sequencer state encoding
//   - REG_IDX_W  : register index width
//   - DEF_SORT_CYCLES : default EX occupancy of a sort instruction
//   - RUN_CNT_W  : width of the sort cycle counter (covers SORT_CYCLES up to 16)
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seqState_e;

  localparam int REG_IDX_W       = 4;
  localparam int DEF_SORT_CYCLES = 4;
  localparam int RUN_CNT_W       = 4;

endpackage

// File: rtl/pipe_hazard_seq_ctrl_hazard_detect.sv
// RAW hazard detection between the instruction in ID and the producers in
// EX/MEM. Purely combinational.
//   idSrc1/idSrc2/idTwoSrc : source indices of the ID instruction
//   exDest/exWbEn/exMemRead: EX producer
//   memDest/memWbEn        : MEM producer
//   fwdEn                  : forwarding unit active
//   hazard                 : ID must stall
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idSrc1,
  input  logic [REG_IDX_W-1:0] idSrc2,
  input  logic                 idTwoSrc,
  input  logic [REG_IDX_W-1:0] exDest,
  input  logic                 exWbEn,
  input  logic                 exMemRead,
  input  logic [REG_IDX_W-1:0] memDest,
  input  logic                 memWbEn,
  input  logic                 fwdEn,
  output logic                 hazard
);

  logic exMatch, memMatch;

  // src2 only counts when the ID instruction actually reads it
  assign exMatch  = (idSrc1 == exDest)  | (idTwoSrc & (idSrc2 == exDest));
  assign memMatch = (idSrc1 == memDest) | (idTwoSrc & (idSrc2 == memDest));

  // With forwarding, only a load in EX cannot be bypassed in time.
  assign hazard = fwdEn ? (exMemRead & exMatch)
                        : ((exWbEn & exMatch) | (memWbEn & memMatch));

endmodule

// File: rtl/pipe_hazard_seq_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
//   Inputs : ID sources / sort flag, EX and MEM producers, fwd_en, branch_taken
//   Outputs: pc_freeze, ifid_freeze, ifid_flush, idex_flush (pipeline controls),
//            sort_out / sort_prev_out (bits latched into ID/EX), sort_busy,
//            stall_cnt / flush_cnt (saturating debug counters)
// Priority: branch_taken > sort RUN > hazard. All controls are combinational
// from inputs and state.
module pipe_hazard_seq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int SORT_CYCLES = DEF_SORT_CYCLES,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_two_src,
  input  logic                 id_sort,
  input  logic [REG_IDX_W-1:0] ex_dest,
  input  logic                 ex_wb_en,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 fwd_en,
  input  logic                 branch_taken,
  output logic                 pc_freeze,
  output logic                 ifid_freeze,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 sort_out,
  output logic                 sort_prev_out,
  output logic                 sort_busy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  // Issue cycle is spent in IDLE, so RUN lasts SORT_CYCLES-1 cycles.
  localparam logic [RUN_CNT_W-1:0] RUN_LOAD = RUN_CNT_W'(SORT_CYCLES - 2);

  seqState_e            state, stateNext;
  logic [RUN_CNT_W-1:0] runCnt, runCntNext;
  logic                 sortPrevQ, sortPrevNext;
  logic [CNT_W-1:0]     stallCntQ, flushCntQ;
  logic                 hazard, stallEvt, flushEvt;

  hazard_detect uHazard (
    .idSrc1    (id_src1),
    .idSrc2    (id_src2),
    .idTwoSrc  (id_two_src),
    .exDest    (ex_dest),
    .exWbEn    (ex_wb_en),
    .exMemRead (ex_mem_read),
    .memDest   (mem_dest),
    .memWbEn   (mem_wb_en),
    .fwdEn     (fwd_en),
    .hazard    (hazard)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      runCnt    <= '0;
      sortPrevQ <= 1'b0;
    end else begin
      state     <= stateNext;
      runCnt    <= runCntNext;
      sortPrevQ <= sortPrevNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext    = state;
    runCntNext   = runCnt;
    sortPrevNext = 1'b0;
    if (branch_taken) begin
      // the sort's slot is flushed, so abandon it
      stateNext  = IDLE;
      runCntNext = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (id_sort && !hazard) begin
            stateNext  = RUN;
            runCntNext = RUN_LOAD;
          end
        end
        RUN: begin
          if (runCnt == '0) begin
            stateNext    = IDLE;
            sortPrevNext = 1'b1;
          end else begin
            runCntNext = runCnt - 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    pc_freeze     = 1'b0;
    ifid_freeze   = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    sort_out      = 1'b0;
    sort_busy     = (state == RUN);
    sort_prev_out = sortPrevQ & ~branch_taken;
    stallEvt      = 1'b0;
    if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state == RUN) begin
      pc_freeze   = 1'b1;
      ifid_freeze = 1'b1;
      idex_flush  = 1'b1;
    end else if (hazard) begin
      pc_freeze   = 1'b1;
      ifid_freeze = 1'b1;
      idex_flush  = 1'b1;
      stallEvt    = 1'b1;
    end else if (id_sort) begin
      sort_out = 1'b1;
    end
  end

  assign flushEvt = branch_taken;

  // Saturating debug counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (stallEvt && (stallCntQ != '1)) stallCntQ <= stallCntQ + CNT_W'(1);
      if (flushEvt && (flushCntQ != '1)) flushCntQ <= flushCntQ + CNT_W'(1);
    end
  end

  assign stall_cnt = stallCntQ;
  assign flush_cnt = flushCntQ;

endmodule

// File: tb/tb_pipe_hazard_seq_ctrl.sv
// Directed bench for pipe_hazard_seq_ctrl (SORT_CYCLES=4, CNT_W=2 so that
// saturation is reachable). Inputs change just after a falling edge;
// outputs are sampled 2 time units later, well before the rising edge.
module tb_pipe_hazard_seq_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int SC = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_src1, id_src2, ex_dest, mem_dest;
  logic id_two_src, id_sort, ex_wb_en, ex_mem_read, mem_wb_en, fwd_en, branch_taken;
  logic pc_freeze, ifid_freeze, ifid_flush, idex_flush, sort_out, sort_prev_out, sort_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int nRun = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  pipe_hazard_seq_ctrl #(.SORT_CYCLES(SC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_sort(id_sort),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
    .branch_taken(branch_taken),
    .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .sort_out(sort_out), .sort_prev_out(sort_prev_out),
    .sort_busy(sort_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc_freeze, ifid_freeze, ifid_flush, idex_flush, sort_out, sort_prev_out, sort_busy}
  function automatic logic [6:0] ctl();
    return {pc_freeze, ifid_freeze, ifid_flush, idex_flush, sort_out, sort_prev_out, sort_busy};
  endfunction

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1101000;
  localparam logic [6:0] C_RUN   = 7'b1101001;
  localparam logic [6:0] C_ISSUE = 7'b0000100;
  localparam logic [6:0] C_PREV  = 7'b0000010;
  localparam logic [6:0] C_B2B   = 7'b0000110;
  localparam logic [6:0] C_BRRUN = 7'b0011001;
  localparam logic [6:0] C_BR    = 7'b0011000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nRun++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clrIn();
    id_src1 = 0; id_src2 = 0; id_two_src = 0; id_sort = 0;
    ex_dest = 0; ex_wb_en = 0; ex_mem_read = 0;
    mem_dest = 0; mem_wb_en = 0; fwd_en = 0; branch_taken = 0;
  endtask

  // advance to the next falling edge (inputs may be changed afterwards)
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic doReset();
    nxt();
    clrIn();
    rst = 1'b0;
    nxt();
    rst = 1'b1;
  endtask

  // a register index that never matches src indices used in sort tests
  initial begin
    rst = 1'b0;
    clrIn();
    // ex_dest/mem_dest = 0 equal id_src = 0 but wb enables are 0: no hazard
    #12;
    chk("reset_ctl", 32'(ctl()), 32'(C_NONE));
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);
    nxt();
    rst = 1'b1;

    // RAW via EX, no forwarding
    nxt(); id_src1 = 3; ex_dest = 3; ex_wb_en = 1; #2;
    chk("raw_ex_ctl", 32'(ctl()), 32'(C_STALL));
    nxt(); clrIn(); #2;
    chk("raw_ex_cnt", 32'(stall_cnt), 1);
    chk("raw_ex_clear", 32'(ctl()), 32'(C_NONE));

    // RAW via MEM on src2, no forwarding
    nxt(); id_src2 = 7; id_two_src = 1; id_src1 = 1; mem_dest = 7; mem_wb_en = 1; ex_dest = 2; #2;
    chk("raw_mem_ctl", 32'(ctl()), 32'(C_STALL));
    // same producer with forwarding on: bypassable, no stall
    nxt(); fwd_en = 1; #2;
    chk("fwd_mem_nostall", 32'(ctl()), 32'(C_NONE));
    nxt(); clrIn(); #2;
    chk("raw_mem_cnt", 32'(stall_cnt), 2);

    // load-use with forwarding
    nxt(); fwd_en = 1; ex_mem_read = 1; ex_wb_en = 1; ex_dest = 5; id_src2 = 5; id_two_src = 1; id_src1 = 1; #2;
    chk("loaduse_ctl", 32'(ctl()), 32'(C_STALL));
    nxt(); ex_mem_read = 0; #2;
    chk("loaduse_noload", 32'(ctl()), 32'(C_NONE));
    nxt(); ex_mem_read = 1; id_two_src = 0; #2;
    chk("loaduse_nosrc2", 32'(ctl()), 32'(C_NONE));
    nxt(); clrIn(); #2;
    chk("loaduse_cnt", 32'(stall_cnt), 3);

    // sort sequencing; hazard presented during RUN must be ignored
    doReset();
    id_sort = 1; #2;
    chk("sort_t0", 32'(ctl()), 32'(C_ISSUE));
    nxt(); id_sort = 0; #2;
    chk("sort_t1", 32'(ctl()), 32'(C_RUN));
    nxt(); id_src1 = 3; ex_dest = 3; ex_wb_en = 1; #2;
    chk("sort_t2_hazard", 32'(ctl()), 32'(C_RUN));
    nxt(); clrIn(); #2;
    chk("sort_t3", 32'(ctl()), 32'(C_RUN));
    nxt(); #2;
    chk("sort_t4_prev", 32'(ctl()), 32'(C_PREV));
    chk("sort_no_stall_cnt", 32'(stall_cnt), 0);
    nxt(); #2;
    chk("sort_t5", 32'(ctl()), 32'(C_NONE));

    // branch abort in RUN t2
    nxt(); id_sort = 1; #2;
    chk("abort_t0", 32'(ctl()), 32'(C_ISSUE));
    nxt(); id_sort = 0; #2;
    chk("abort_t1", 32'(ctl()), 32'(C_RUN));
    nxt(); branch_taken = 1; #2;
    chk("abort_t2", 32'(ctl()), 32'(C_BRRUN));
    nxt(); branch_taken = 0; #2;
    chk("abort_t3", 32'(ctl()), 32'(C_NONE));
    chk("abort_flush_cnt", 32'(flush_cnt), 1);
    nxt(); #2;
    chk("abort_t4_noprev", 32'(ctl()), 32'(C_NONE));

    // back-to-back sorts
    nxt(); id_sort = 1; #2;
    chk("b2b_t0", 32'(ctl()), 32'(C_ISSUE));
    nxt(); id_sort = 0;
    nxt(); nxt();
    nxt(); id_sort = 1; #2;
    chk("b2b_t4", 32'(ctl()), 32'(C_B2B));
    nxt(); id_sort = 0; #2;
    chk("b2b_t5", 32'(ctl()), 32'(C_RUN));
    nxt(); nxt(); nxt(); #2;
    chk("b2b_t8_prev", 32'(ctl()), 32'(C_PREV));
    // branch in the prev cycle suppresses sort_prev_out immediately
    nxt(); id_sort = 1;
    nxt(); id_sort = 0;
    nxt(); nxt(); nxt(); branch_taken = 1; #2;
    chk("prev_branch_kill", 32'(ctl()), 32'(C_BR));
    nxt(); branch_taken = 0; #2;
    chk("prev_branch_after", 32'(ctl()), 32'(C_NONE));

    // async reset mid-RUN, with a hazard present
    nxt(); id_sort = 1;
    nxt(); id_sort = 0; #2;
    chk("rst_pre_busy", 32'(sort_busy), 1);
    #1; rst = 0; #1;
    chk("rst_async_ctl", 32'(ctl()), 32'(C_NONE));
    chk("rst_async_stall", 32'(stall_cnt), 0);
    chk("rst_async_flush", 32'(flush_cnt), 0);
    id_src1 = 4; ex_dest = 4; ex_wb_en = 1; #1;
    chk("rst_hazard_ctl", 32'(ctl()), 32'(C_STALL));
    nxt(); clrIn(); rst = 1;

    // branch beats hazard: flush counted, stall not
    nxt(); branch_taken = 1; id_src1 = 6; ex_dest = 6; ex_wb_en = 1; #2;
    chk("br_hazard_ctl", 32'(ctl()), 32'(C_BR));
    nxt(); branch_taken = 0; #2;
    chk("br_hazard_stall", 32'(stall_cnt), 0);
    chk("br_hazard_flush", 32'(flush_cnt), 1);

    // hazard still applied: 5 stall cycles saturate a 2-bit counter
    nxt(); nxt(); nxt(); nxt();
    nxt(); clrIn(); #2;
    chk("stall_sat", 32'(stall_cnt), 3);
    // 4 flushes saturate too
    nxt(); branch_taken = 1;
    nxt(); nxt(); nxt();
    nxt(); branch_taken = 0; #2;
    chk("flush_sat", 32'(flush_cnt), 3);

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_seq_ctrl.md
Name: pipe_hazard_seq_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage ARM core.
- Detects RAW hazards between ID and EX/MEM, and generates the PC/IF-ID freeze and IF-ID/ID-EX flush controls.
- Sequences the multi-cycle sort instruction through the ID/EX stage, driving the sort and sort_prev bits that the ID/EX register latches.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- SORT_CYCLES, 4: total EX occupancy of a sort instruction in cycles (legal range 2..16).
- CNT_W, 16: width of the stall and flush event counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_src1  in  4  Rn index of the instruction in ID
- id_src2  in  4  Rm/Rd index of the instruction in ID
- id_two_src  in  1  instruction in ID reads id_src2
- id_sort  in  1  instruction in ID is a sort
- ex_dest  in  4  destination register in EX
- ex_wb_en  in  1  EX instruction writes back
- ex_mem_read  in  1  EX instruction is a load
- mem_dest  in  4  destination register in MEM
- mem_wb_en  in  1  MEM instruction writes back
- fwd_en  in  1  forwarding unit enabled
- branch_taken  in  1  EX resolves a taken branch
- pc_freeze  out  1  hold PC
- ifid_freeze  out  1  hold the IF/ID register
- ifid_flush  out  1  clear the IF/ID register
- idex_flush  out  1  clear the ID/EX register (insert a bubble)
- sort_out  out  1  sort bit into ID/EX
- sort_prev_out  out  1  sort_prev bit into ID/EX
- sort_busy  out  1  sort FSM is in RUN
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles
- flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cycle counter=0, sort_prev_q=0, stall_cnt=0, flush_cnt=0.
  - With reset active and all inputs 0, every output is 0.
- Hazard term (combinational):
  - src2 match is qualified by id_two_src.
  - fwd_en=0: hazard = (ex_wb_en & match(ex_dest)) | (mem_wb_en & match(mem_dest)).
  - fwd_en=1: hazard = ex_mem_read & match(ex_dest).
- Priority, highest first: branch_taken, sort RUN, hazard.
- branch_taken=1 (any state):
  - ifid_flush=1, idex_flush=1; pc_freeze=0, ifid_freeze=0.
  - Next state is IDLE and the counter clears; this aborts a sort in progress, because the sort's pipeline slot is flushed.
  - flush_cnt increments next edge.
- State IDLE:
  - hazard=1: pc_freeze=ifid_freeze=idex_flush=1; stall_cnt increments.
  - id_sort=1 and hazard=0: sort_out=1 this cycle, so the sort enters ID/EX. Next state RUN with counter=SORT_CYCLES-2.
- State RUN (sort occupying EX):
  - pc_freeze=ifid_freeze=idex_flush=1 and sort_busy=1.
  - hazard is ignored and stall_cnt does not count.
  - counter=0: next state IDLE and sort_prev_q is set to 1; otherwise the counter decrements.
- sort_prev_out:
  - Equals sort_prev_q, high for exactly one cycle: the first IDLE cycle after RUN.
  - It is cleared on the next edge, or immediately if branch_taken=1.
- Back-to-back sorts:
  - id_sort=1 in that first IDLE cycle restarts RUN.
  - In that cycle sort_out=1 and sort_prev_out=1 together.
- Latency:
  - Controls are combinational from inputs and state, within the same cycle.
  - A sort holds fetch for exactly SORT_CYCLES-1 cycles after it issues.
- Counters:
  - Saturate at all-ones with no wrap.
  - Simultaneous increment events count once.
- Reset asserted mid-RUN: the FSM returns to IDLE immediately, and freeze/flush deassert unless a hazard is present.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding (IDLE=1'b0, RUN=1'b1)
  - REG_IDX_W=4
  - default SORT_CYCLES
- One natural sub-module: hazard_detect.
  - Purely combinational: src/dest match plus fwd_en qualification.
  - Instantiated once.
  - The FSM, counters and priority mux stay in the top.

Test Plan:
- RAW stall, no forwarding:
  - Stimulus: fwd_en=0, id_src1=3, ex_dest=3, ex_wb_en=1 for 1 cycle.
  - Response: pc_freeze=ifid_freeze=idex_flush=1 that cycle; stall_cnt 0->1.
- Load-use with forwarding:
  - Stimulus: fwd_en=1, ex_mem_read=1, ex_dest=5, id_src2=5, id_two_src=1.
  - Response: stall asserted.
  - Same stimulus with ex_mem_read=0: no stall.
  - Same stimulus with id_two_src=0: no stall.
- Sort sequencing:
  - Stimulus: SORT_CYCLES=4, id_sort=1 for 1 cycle.
  - Response: sort_out=1 at t0; sort_busy=1 with freeze/flush=1 at t1..t3; sort_prev_out=1 at t4 only.
- Branch abort:
  - Stimulus: branch_taken=1 during RUN cycle t2.
  - Response: ifid_flush=idex_flush=1; FSM in IDLE at t3; sort_prev_out=0; flush_cnt=1.
- Back-to-back sort:
  - Stimulus: id_sort=1 again at t4.
  - Response: sort_out=1 and sort_prev_out=1 at t4; sort_busy=1 at t5.
- Reset and saturation:
  - Stimulus: rst=0 mid-RUN.
  - Response: sort_busy=0 asynchronously, counters 0.
  - Stimulus: CNT_W=2 with 5 stall cycles.
  - Response: stall_cnt=3.
